// File: rtl/pc_fetch_sequencer.sv
// PC fetch sequencer: next-PC selection, PC load enable and imem fetch handshake with timeout.
// Optional exception entry (exc_req/epc ports) enabled by defining EXC_VECTOR_EN.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
    parameter int          TIMEOUT    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        stall,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        jr_valid,
    input  logic [31:0] jr_target,
`ifdef EXC_VECTOR_EN
    input  logic        exc_req,
    output logic [31:0] epc,
`endif
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    output logic        pc_en,
    output logic [31:0] npc,
    output logic        fetch_err
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_ERR
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   wait_cnt, wait_cnt_n;
    logic            pend_v;
    logic [31:0]     pend_tgt;
    logic            active;
    logic            exc_take;

    assign active = (state == S_REQ) || (state == S_WAIT) || (state == S_HOLD);

`ifdef EXC_VECTOR_EN
    assign exc_take = exc_req && active;
`else
    assign exc_take = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_cnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        wait_cnt_n = wait_cnt;
        imem_req   = 1'b0;
        pc_en      = 1'b0;
        case (state)
            S_IDLE: state_n = S_REQ;
            S_REQ, S_WAIT: begin
                imem_req = 1'b1;
                if (exc_take || (imem_ack && !stall)) begin
                    pc_en      = 1'b1;
                    state_n    = S_REQ;
                    wait_cnt_n = '0;
                end else if (imem_ack) begin
                    state_n    = S_HOLD;
                    wait_cnt_n = '0;
                end else if (state == S_REQ) begin
                    state_n    = S_WAIT;
                    wait_cnt_n = CW'(1);
                end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                    state_n = S_ERR;
                end else begin
                    wait_cnt_n = wait_cnt + CW'(1);
                end
            end
            S_HOLD: begin
                if (exc_take || !stall) begin
                    pc_en      = 1'b1;
                    state_n    = S_REQ;
                    wait_cnt_n = '0;
                end
            end
            S_ERR:   state_n = S_ERR;
            default: state_n = S_IDLE;
        endcase
    end

    // Live redirects outrank a buffered one; jr beats br when both pulse together.
    always_comb begin
        if (state == S_IDLE)  npc = RESET_PC;
        else if (exc_take)    npc = EXC_VECTOR;
        else if (jr_valid)    npc = jr_target;
        else if (br_valid)    npc = br_target;
        else if (pend_v)      npc = pend_tgt;
        else                  npc = pc + 32'd4;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_v   <= 1'b0;
            pend_tgt <= '0;
        end else if (active) begin
            if (pc_en) begin
                pend_v <= 1'b0;
            end else if (jr_valid) begin
                pend_v   <= 1'b1;
                pend_tgt <= jr_target;
            end else if (br_valid) begin
                pend_v   <= 1'b1;
                pend_tgt <= br_target;
            end
        end
    end

`ifdef EXC_VECTOR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            epc <= '0;
        else if (exc_take)
            epc <= pc;
    end
`endif

    assign imem_addr = pc;
    assign fetch_err = (state == S_ERR);

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: directed scenarios plus randomized traffic against a behavioural model.
// Exception ports are tied off when built with EXC_VECTOR_EN.
module tb_pc_fetch_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam int          TIMEOUT  = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc = RESET_PC;
    logic        stall = 1'b0;
    logic        br_valid = 1'b0;
    logic [31:0] br_target = '0;
    logic        jr_valid = 1'b0;
    logic [31:0] jr_target = '0;
    logic        imem_ack = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        pc_en;
    logic [31:0] npc;
    logic        fetch_err;
`ifdef EXC_VECTOR_EN
    logic        exc_req = 1'b0;
    logic [31:0] epc;
`endif

    int checks = 0;
    int errors = 0;

    // Behavioural model: fetch started, holding on stall, errored, cycles waited, buffered redirect
    logic        m_started, m_hold, m_err, m_pend_v;
    int          m_wait;
    logic [31:0] m_pend_tgt;
    logic        exp_req, exp_pc_en;
    logic [31:0] exp_npc;

    pc_fetch_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .pc        (pc),
        .stall     (stall),
        .br_valid  (br_valid),
        .br_target (br_target),
        .jr_valid  (jr_valid),
        .jr_target (jr_target),
`ifdef EXC_VECTOR_EN
        .exc_req   (exc_req),
        .epc       (epc),
`endif
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .pc_en     (pc_en),
        .npc       (npc),
        .fetch_err (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic model_init();
        m_started  = 1'b0;
        m_hold     = 1'b0;
        m_err      = 1'b0;
        m_pend_v   = 1'b0;
        m_wait     = 0;
        m_pend_tgt = '0;
        pc         = RESET_PC;
    endtask

    task automatic model_eval();
        logic [31:0] tgt;
        exp_req   = m_started && !m_err && !m_hold;
        exp_pc_en = (exp_req && imem_ack && !stall) || (m_hold && !stall);
        if (jr_valid)      tgt = jr_target;
        else if (br_valid) tgt = br_target;
        else if (m_pend_v) tgt = m_pend_tgt;
        else               tgt = pc + 32'd4;
        exp_npc = m_started ? tgt : RESET_PC;
    endtask

    task automatic model_update();
        if (!m_started) begin
            m_started = 1'b1;
        end else if (!m_err) begin
            if (exp_pc_en) begin
                m_pend_v = 1'b0;
                m_hold   = 1'b0;
                m_wait   = 0;
            end else begin
                if (jr_valid) begin
                    m_pend_v = 1'b1; m_pend_tgt = jr_target;
                end else if (br_valid) begin
                    m_pend_v = 1'b1; m_pend_tgt = br_target;
                end
                if (exp_req && imem_ack) begin
                    m_hold = 1'b1;
                    m_wait = 0;
                end else if (exp_req) begin
                    m_wait++;
                    if (m_wait == TIMEOUT) m_err = 1'b1;
                end
            end
        end
    endtask

    task automatic drive(input logic s, input logic a, input logic b, input logic [31:0] bt,
                         input logic j, input logic [31:0] jt);
        @(negedge clk);
        stall = s; imem_ack = a; br_valid = b; br_target = bt; jr_valid = j; jr_target = jt;
        #1;
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_update();
        if (exp_pc_en) pc = exp_npc;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        stall = 1'b0; imem_ack = 1'b0; br_valid = 1'b0; jr_valid = 1'b0;
        model_init();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        model_init();
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", imem_req); end
        checks++; if (pc_en !== 1'b0) begin errors++; $display("FAIL rst_pc_en got %b want 0", pc_en); end
        checks++; if (npc !== RESET_PC) begin errors++; $display("FAIL rst_npc got %h want %h", npc, RESET_PC); end
        checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", fetch_err); end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_t1_stream();
        drive(0, 1, 0, 0, 0, 0);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL t1_idle_req got %b want 0", imem_req); end
        tick();
        drive(0, 1, 0, 0, 0, 0);
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL t1_req got %b want 1", imem_req); end
        checks++; if (pc_en !== 1'b1 || npc !== 32'h3004) begin errors++; $display("FAIL t1_first got pc_en=%b npc=%h want 1 00003004", pc_en, npc); end
        tick();
        drive(0, 1, 0, 0, 0, 0);
        checks++; if (pc_en !== 1'b1 || npc !== 32'h3008) begin errors++; $display("FAIL t1_second got pc_en=%b npc=%h want 1 00003008", pc_en, npc); end
        tick();
    endtask

    task automatic test_t2_wait();
        pc = 32'h3010;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            checks++; if (pc_en !== 1'b0 || imem_req !== 1'b1) begin errors++; $display("FAIL t2_wait%0d got pc_en=%b req=%b want 0 1", i, pc_en, imem_req); end
            tick();
        end
        drive(0, 1, 0, 0, 0, 0);
        checks++; if (pc_en !== 1'b1 || npc !== 32'h3014) begin errors++; $display("FAIL t2_ack got pc_en=%b npc=%h want 1 00003014", pc_en, npc); end
        checks++; if (imem_addr !== 32'h3010) begin errors++; $display("FAIL t2_addr got %h want 00003010", imem_addr); end
        tick();
    endtask

    task automatic test_t3_timeout();
        int reqc = 0;
        do_reset();
        drive(0, 0, 0, 0, 0, 0);
        tick();
        for (int n = 0; n < 40; n++) begin
            drive(0, 0, 0, 0, 0, 0);
            if (fetch_err) break;
            if (imem_req) reqc++;
            tick();
        end
        checks++; if (fetch_err !== 1'b1) begin errors++; $display("FAIL t3_err got %b want 1 (timed out)", fetch_err); end
        checks++; if (reqc != TIMEOUT) begin errors++; $display("FAIL t3_req_cycles got %0d want %0d", reqc, TIMEOUT); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL t3_req_off got %b want 0", imem_req); end
        tick();
        drive(0, 1, 1, 32'h3100, 0, 0);
        checks++; if (fetch_err !== 1'b1 || pc_en !== 1'b0) begin errors++; $display("FAIL t3_sticky got err=%b pc_en=%b want 1 0", fetch_err, pc_en); end
        tick();
    endtask

    task automatic test_t4_hold_redirect();
        do_reset();
        drive(0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 1, 1, 32'h3100, 0, 0);
        checks++; if (pc_en !== 1'b0) begin errors++; $display("FAIL t4_stall got pc_en=%b want 0", pc_en); end
        tick();
        drive(1, 1, 0, 0, 0, 0);
        checks++; if (imem_req !== 1'b0 || pc_en !== 1'b0) begin errors++; $display("FAIL t4_hold got req=%b pc_en=%b want 0 0", imem_req, pc_en); end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        checks++; if (pc_en !== 1'b1 || npc !== 32'h3100) begin errors++; $display("FAIL t4_release got pc_en=%b npc=%h want 1 00003100", pc_en, npc); end
        tick();
        drive(0, 1, 0, 0, 0, 0);
        checks++; if (pc_en !== 1'b1 || npc !== 32'h3104) begin errors++; $display("FAIL t4_next got pc_en=%b npc=%h want 1 00003104", pc_en, npc); end
        tick();
    endtask

    task automatic test_t5_jr_over_br();
        drive(0, 1, 1, 32'h3200, 1, 32'h3300);
        checks++; if (pc_en !== 1'b1 || npc !== 32'h3300) begin errors++; $display("FAIL t5_jr got pc_en=%b npc=%h want 1 00003300", pc_en, npc); end
        tick();
        drive(0, 1, 0, 0, 0, 0);
        checks++; if (npc !== 32'h3304) begin errors++; $display("FAIL t5_no_pend got %h want 00003304", npc); end
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL ar_wait_req got %b want 1", imem_req); end
        #1;
        reset = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0 || npc !== RESET_PC) begin errors++; $display("FAIL ar_drop got req=%b npc=%h want 0 %h", imem_req, npc, RESET_PC); end
        model_init();
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_random();
        for (int seg = 0; seg < 4; seg++) begin
            int ack_div = (seg == 2) ? 8 : 4;
            do_reset();
            for (int c = 0; c < 120; c++) begin
                logic s, a, b, j;
                logic [31:0] bt, jt;
                s  = ($urandom % 4) == 0;
                a  = (seg == 2) ? (($urandom % ack_div) == 0) : (($urandom % ack_div) != 0);
                b  = ($urandom % 6) == 0;
                j  = ($urandom % 8) == 0;
                bt = $urandom & 32'hFFFF_FFFC;
                jt = $urandom & 32'hFFFF_FFFC;
                drive(s, a, b, bt, j, jt);
                checks++; if (imem_req !== exp_req) begin errors++; $display("FAIL rnd_req c%0d got %b want %b", c, imem_req, exp_req); end
                checks++; if (pc_en !== exp_pc_en) begin errors++; $display("FAIL rnd_pc_en c%0d got %b want %b", c, pc_en, exp_pc_en); end
                checks++; if (fetch_err !== m_err) begin errors++; $display("FAIL rnd_err c%0d got %b want %b", c, fetch_err, m_err); end
                checks++; if (imem_addr !== pc) begin errors++; $display("FAIL rnd_addr c%0d got %h want %h", c, imem_addr, pc); end
                if (exp_pc_en || !m_started) begin
                    checks++; if (npc !== exp_npc) begin errors++; $display("FAIL rnd_npc c%0d got %h want %h", c, npc, exp_npc); end
                end
                tick();
            end
        end
    endtask

    initial begin
        model_init();
        test_reset();
        test_t1_stream();
        test_t2_wait();
        test_t3_timeout();
        test_t4_hold_redirect();
        test_t5_jr_over_br();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
